// File: rtl/bcd_displays_seq.sv
// bcd_displays_seq: sequential binary-to-seven-segment converter for N_DIG displays.
// A start/busy/done handshake launches a double-dabble conversion that consumes one
// input bit per clock. Segment patterns and the out-of-range flag are registered and
// held until the next conversion completes.
// Optional feature: define LZ_BLANK_EN to blank leading zero digits.
module bcd_displays_seq #(
   parameter int N_in  = 10,
   parameter int N_DIG = 4
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 start,
   input  logic [N_in-1:0]      bin_in,
   output logic                 busy,
   output logic                 done,
   output logic                 ovf,
   output logic [7*N_DIG-1:0]   D_out
);

   localparam int BCD_W = 4 * N_DIG;
   localparam int CNT_W = $clog2(N_in + 1);
   // Wide enough to hold both the input value and 10^N_DIG (< 2^(4*N_DIG)).
   localparam int CMP_W = ((N_in > BCD_W) ? N_in : BCD_W) + 1;

   localparam logic [6:0] SEG_BLANK = 7'b1111111;
   localparam logic [6:0] SEG_DASH  = 7'b0111111;

   // 10^n evaluated at elaboration; multiply by 10 as (x<<3)+(x<<1) to stay in width.
   function automatic logic [CMP_W-1:0] pow10(input int n);
      logic [CMP_W-1:0] p;
      p = CMP_W'(1);
      for (int k = 0; k < n; k++) begin
         p = (p << 3) + (p << 1);
      end
      return p;
   endfunction

   localparam logic [CMP_W-1:0] OVF_LIMIT = pow10(N_DIG);

   // Active-low segment pattern {g,f,e,d,c,b,a} for one BCD digit.
   function automatic logic [6:0] seg7(input logic [3:0] d);
      logic [6:0] s;
      case (d)
         4'd0:    s = 7'b1000000;
         4'd1:    s = 7'b1111001;
         4'd2:    s = 7'b0100100;
         4'd3:    s = 7'b0110000;
         4'd4:    s = 7'b0011001;
         4'd5:    s = 7'b0010010;
         4'd6:    s = 7'b0000010;
         4'd7:    s = 7'b1111000;
         4'd8:    s = 7'b0000000;
         4'd9:    s = 7'b0010000;
         default: s = SEG_BLANK;
      endcase
      return s;
   endfunction

   typedef enum logic {IDLE, SHIFT} state_t;

   state_t               state_q, state_d;
   logic [N_in-1:0]      bin_q, bin_d;
   logic [BCD_W-1:0]     bcd_q, bcd_d;
   logic [CNT_W-1:0]     cnt_q, cnt_d;
   logic                 busy_q, busy_d;
   logic                 done_q, done_d;
   logic                 ovf_q, ovf_d;
   logic                 ovf_pend_q, ovf_pend_d;
   logic [7*N_DIG-1:0]   seg_q, seg_d;

   // Datapath of one double-dabble step.
   logic [BCD_W-1:0]       bcd_adj;
   logic [BCD_W+N_in-1:0]  comb_shift;
   logic [BCD_W-1:0]       bcd_shift;
   logic [N_in-1:0]        bin_shift;
   logic [7*N_DIG-1:0]     seg_dig;
   logic [7*N_DIG-1:0]     seg_lz;
   logic [7*N_DIG-1:0]     seg_final;

   genvar gi;
   generate
      for (gi = 0; gi < N_DIG; gi++) begin : g_adj
         assign bcd_adj[4*gi +: 4] = (bcd_q[4*gi +: 4] >= 4'd5) ?
                                     bcd_q[4*gi +: 4] + 4'd3 : bcd_q[4*gi +: 4];
      end
   endgenerate

   // Bits pushed past the top nibble fall off; ovf masks the display in that case.
   assign comb_shift = {bcd_adj, bin_q} << 1;
   assign bcd_shift  = comb_shift[BCD_W+N_in-1:N_in];
   assign bin_shift  = comb_shift[N_in-1:0];

   // Decode the accumulator as it will be after the final shift.
   generate
      for (gi = 0; gi < N_DIG; gi++) begin : g_dec
         assign seg_dig[7*gi +: 7] = seg7(bcd_shift[4*gi +: 4]);
`ifdef LZ_BLANK_EN
         if (gi == 0) begin : g_units
            assign seg_lz[6:0] = seg_dig[6:0];
         end else begin : g_upper
            // A digit is shown only if it or some more significant digit is nonzero.
            logic keep;
            assign keep = |bcd_shift[BCD_W-1:4*gi];
            assign seg_lz[7*gi +: 7] = keep ? seg_dig[7*gi +: 7] : SEG_BLANK;
         end
`else
         assign seg_lz[7*gi +: 7] = seg_dig[7*gi +: 7];
`endif
      end
   endgenerate

   assign seg_final = ovf_pend_q ? {N_DIG{SEG_DASH}} : seg_lz;

   // Next-state logic: accept a start in IDLE, run N_in shift steps in SHIFT.
   always_comb begin
      state_d    = state_q;
      bin_d      = bin_q;
      bcd_d      = bcd_q;
      cnt_d      = cnt_q;
      busy_d     = busy_q;
      done_d     = 1'b0;
      ovf_d      = ovf_q;
      ovf_pend_d = ovf_pend_q;
      seg_d      = seg_q;
      case (state_q)
         IDLE: begin
            if (start) begin
               bin_d      = bin_in;
               bcd_d      = '0;
               cnt_d      = CNT_W'(N_in);
               busy_d     = 1'b1;
               ovf_pend_d = (CMP_W'(bin_in) >= OVF_LIMIT);
               state_d    = SHIFT;
            end
         end
         SHIFT: begin
            bin_d = bin_shift;
            bcd_d = bcd_shift;
            cnt_d = cnt_q - CNT_W'(1);
            if (cnt_q == CNT_W'(1)) begin
               state_d = IDLE;
               busy_d  = 1'b0;
               done_d  = 1'b1;
               ovf_d   = ovf_pend_q;
               seg_d   = seg_final;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // State and output registers with synchronous reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= IDLE;
         bin_q      <= '0;
         bcd_q      <= '0;
         cnt_q      <= '0;
         busy_q     <= 1'b0;
         done_q     <= 1'b0;
         ovf_q      <= 1'b0;
         ovf_pend_q <= 1'b0;
         seg_q      <= {N_DIG{SEG_BLANK}};
      end else begin
         state_q    <= state_d;
         bin_q      <= bin_d;
         bcd_q      <= bcd_d;
         cnt_q      <= cnt_d;
         busy_q     <= busy_d;
         done_q     <= done_d;
         ovf_q      <= ovf_d;
         ovf_pend_q <= ovf_pend_d;
         seg_q      <= seg_d;
      end
   end

   assign busy  = busy_q;
   assign done  = done_q;
   assign ovf   = ovf_q;
   assign D_out = seg_q;

endmodule

// File: tb/tb_bcd_displays_seq.sv
// Bench for bcd_displays_seq: a 4-digit and a 3-digit instance, an arithmetic
// reference model checked every cycle, and directed literal checks.
module tb_bcd_displays_seq;

   localparam int N_IN = 10;

   logic        clk = 1'b0;
   logic        rst;
   logic        start4, start3;
   logic [9:0]  bin4, bin3;
   logic        busy4, done4, ovf4, busy3, done3, ovf3;
   logic [27:0] dout4;
   logic [20:0] dout3;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   bcd_displays_seq #(.N_in(N_IN), .N_DIG(4)) dut4 (
      .clk(clk), .rst(rst), .start(start4), .bin_in(bin4),
      .busy(busy4), .done(done4), .ovf(ovf4), .D_out(dout4)
   );

   bcd_displays_seq #(.N_in(N_IN), .N_DIG(3)) dut3 (
      .clk(clk), .rst(rst), .start(start3), .bin_in(bin3),
      .busy(busy3), .done(done3), .ovf(ovf3), .D_out(dout3)
   );

   function automatic int pow10i(input int n);
      int p;
      p = 1;
      for (int k = 0; k < n; k++) p = p * 10;
      return p;
   endfunction

   function automatic logic [6:0] seg_of(input int d);
      case (d)
         0: return 7'b1000000;
         1: return 7'b1111001;
         2: return 7'b0100100;
         3: return 7'b0110000;
         4: return 7'b0011001;
         5: return 7'b0010010;
         6: return 7'b0000010;
         7: return 7'b1111000;
         8: return 7'b0000000;
         9: return 7'b0010000;
         default: return 7'b1111111;
      endcase
   endfunction

   // Expected display word for value v on nd digits (unused upper digits blank).
   function automatic logic [27:0] disp(input int v, input int nd);
      logic [27:0] r;
      int p;
      r = '1;
      if (v >= pow10i(nd)) begin
         for (int i = 0; i < nd; i++) r[7*i +: 7] = 7'b0111111;
      end else begin
         p = 1;
         for (int i = 0; i < nd; i++) begin
            r[7*i +: 7] = seg_of((v / p) % 10);
`ifdef LZ_BLANK_EN
            if (i > 0 && v < p) r[7*i +: 7] = 7'b1111111;
`endif
            p = p * 10;
         end
      end
      return r;
   endfunction

   // Reference model: result appears N_IN edges after the accepting edge.
   int          cyc = 0;
   logic        m_busy[2];
   logic        m_done[2];
   logic        m_ovf[2];
   logic [27:0] m_seg[2];
   int          m_due[2];
   int          m_val[2];

   always @(posedge clk) begin
      cyc <= cyc + 1;
      for (int m = 0; m < 2; m++) begin
         if (rst) begin
            m_busy[m] <= 1'b0;
            m_done[m] <= 1'b0;
            m_ovf[m]  <= 1'b0;
            m_seg[m]  <= '1;
         end else begin
            m_done[m] <= 1'b0;
            if (!m_busy[m]) begin
               if ((m == 0) ? start4 : start3) begin
                  m_busy[m] <= 1'b1;
                  m_due[m]  <= cyc + N_IN;
                  m_val[m]  <= int'((m == 0) ? bin4 : bin3);
               end
            end else if (cyc == m_due[m]) begin
               m_busy[m] <= 1'b0;
               m_done[m] <= 1'b1;
               m_ovf[m]  <= (m_val[m] >= pow10i((m == 0) ? 4 : 3));
               m_seg[m]  <= disp(m_val[m], (m == 0) ? 4 : 3);
            end
         end
      end
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h want %0h", name, act, exp);
      end
   endtask

   // Compare both instances against the model.
   task automatic cmp_cycle();
      logic [30:0] act_v, exp_v;
      for (int m = 0; m < 2; m++) begin
         exp_v = {m_busy[m], m_done[m], m_ovf[m], m_seg[m]};
         act_v = (m == 0) ? {busy4, done4, ovf4, dout4}
                          : {busy3, done3, ovf3, 7'h7f, dout3};
         checks++;
         if (act_v !== exp_v) begin
            errors++;
            $display("FAIL model_dut%0d t=%0t: got %h want %h", m, $time, act_v, exp_v);
         end
      end
   endtask

   // One clock: move to the falling edge and check every output.
   task automatic tick();
      @(negedge clk);
      cmp_cycle();
   endtask

   // Start a conversion on instance m and return cycles until done (-1 on timeout).
   task automatic run(input int m, input int v, output int n);
      tick();
      if (m == 0) begin start4 = 1'b1; bin4 = 10'(v); end
      else        begin start3 = 1'b1; bin3 = 10'(v); end
      tick();
      start4 = 1'b0;
      start3 = 1'b0;
      n = -1;
      for (int i = 1; i <= 40; i++) begin
         tick();
         if (((m == 0) ? done4 : done3) === 1'b1) begin
            n = i;
            break;
         end
      end
      $display("run dut%0d value=%0d latency=%0d", m, v, n);
   endtask

   task automatic count_dones(input int cycles, output int cnt);
      cnt = 0;
      for (int i = 0; i < cycles; i++) begin
         tick();
         if (done4 === 1'b1) cnt++;
      end
   endtask

   initial begin
      int n;
      int cnt;
      int last;
      int ndone;

      rst = 1'b1; start4 = 1'b0; start3 = 1'b0; bin4 = '0; bin3 = '0;
      repeat (3) tick();
      chk("reset_flags", {busy4, done4, ovf4, busy3, done3, ovf3}, 0);
      chk("reset_dout4", dout4, 28'hfffffff);
      chk("reset_dout3", dout3, 21'h1fffff);
      rst = 1'b0;
      tick();

      run(0, 1023, n);
      chk("lat_1023", n, 10);
      chk("dout_1023", dout4, {7'b1111001, 7'b1000000, 7'b0100100, 7'b0110000});
      chk("ovf_1023", ovf4, 0);

      run(0, 0, n);
`ifdef LZ_BLANK_EN
      chk("dout_0", dout4, {7'b1111111, 7'b1111111, 7'b1111111, 7'b1000000});
`else
      chk("dout_0", dout4, {7'b1000000, 7'b1000000, 7'b1000000, 7'b1000000});
`endif
      chk("ovf_0", ovf4, 0);

      run(0, 42, n);
`ifdef LZ_BLANK_EN
      chk("dout_42", dout4, {7'b1111111, 7'b1111111, 7'b0011001, 7'b0100100});
`else
      chk("dout_42", dout4, {7'b1000000, 7'b1000000, 7'b0011001, 7'b0100100});
`endif

      run(1, 999, n);
      chk("lat3_999", n, 10);
      chk("dout3_999", dout3, {7'b0010000, 7'b0010000, 7'b0010000});
      chk("ovf3_999", ovf3, 0);
      run(1, 1000, n);
      chk("dout3_1000", dout3, {7'b0111111, 7'b0111111, 7'b0111111});
      chk("ovf3_1000", ovf3, 1);

      // start while busy is ignored and bin_in changes do not matter
      tick();
      start4 = 1'b1; bin4 = 10'd700;
      tick();
      start4 = 1'b0;
      tick();
      tick();
      start4 = 1'b1; bin4 = 10'd5;
      tick();
      chk("busy_at_ignored_start", busy4, 1);
      start4 = 1'b0; bin4 = 10'd0;
      n = -1;
      for (int i = 1; i <= 40; i++) begin
         tick();
         if (done4 === 1'b1) begin n = 3 + i; break; end
      end
      $display("run dut0 value=700 with ignored start latency=%0d", n);
      chk("lat_700", n, 10);
`ifdef LZ_BLANK_EN
      chk("dout_700", dout4, {7'b1111111, 7'b1111000, 7'b1000000, 7'b1000000});
`else
      chk("dout_700", dout4, {7'b1000000, 7'b1111000, 7'b1000000, 7'b1000000});
`endif
      count_dones(20, cnt);
      chk("no_second_done", cnt, 0);

      // reset in the middle of a conversion aborts it
      tick();
      start4 = 1'b1; bin4 = 10'd123;
      tick();
      start4 = 1'b0;
      repeat (4) tick();
      rst = 1'b1;
      tick();
      chk("midrst_flags", {busy4, done4, ovf4}, 0);
      chk("midrst_dout", dout4, 28'hfffffff);
      rst = 1'b0;
      count_dones(20, cnt);
      chk("midrst_no_done", cnt, 0);
      run(0, 123, n);
      chk("lat_123", n, 10);
`ifdef LZ_BLANK_EN
      chk("dout_123", dout4, {7'b1111111, 7'b1111001, 7'b0100100, 7'b0110000});
`else
      chk("dout_123", dout4, {7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000});
`endif

      // back-to-back: start held high, new random bin_in every cycle
      tick();
      start4 = 1'b1;
      bin4 = 10'($urandom_range(0, 1023));
      ndone = 0;
      last = 0;
      for (int i = 1; i <= 120 && ndone < 5; i++) begin
         tick();
         bin4 = 10'($urandom_range(0, 1023));
         if (done4 === 1'b1) begin
            ndone++;
            $display("b2b done %0d at cycle %0d dout=%h ovf=%0d", ndone, i, dout4, ovf4);
            if (ndone > 1) chk("b2b_period", i - last, 11);
            last = i;
         end
      end
      chk("b2b_count", ndone, 5);
      start4 = 1'b0;
      repeat (15) tick();

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
